uart_tx_buf: RTL and testbench

- Parametrised, buffered UART transmitter; next generation of the fixed 8N1 single-byte UART_TX.
- Accepts words through a write-strobe interface into an internal FIFO and serialises them back-to-back on one TX line.
- Data width, parity mode, stop-bit count, baud rate and FIFO depth are configurable.
- Sits between the board-level control logic (push-button or host command paths in the UART top) and the TX pin.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/uart_tx_buf.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_buf.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the buffered UART transmitter:
//                parity-mode constants, FSM state encoding and the
//                clocks-per-bit divider calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Parity modes selected by the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Transmit FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Clocks per bit, rounded to nearest
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with pointer-MSB full/empty detection,
//                occupancy output and registered read data that updates on
//                the pop edge. Synchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     i_fWr,
    input  logic [DATA_W-1:0]        i_WrData,
    input  logic                     i_fRd,
    output logic [DATA_W-1:0]        o_RdData,
    output logic                     o_fFull,
    output logic                     o_fEmpty,
    output logic [$clog2(DEPTH):0]   o_Level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_rd_data;
    logic              w_wr_en;
    logic              w_rd_en;

    // Full/empty come from pre-edge pointers, so a write coinciding with a
    // pop from a full FIFO is still refused.
    assign o_fFull  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_fEmpty = (r_wr_ptr == r_rd_ptr);
    assign o_Level  = r_wr_ptr - r_rd_ptr;
    assign o_RdData = r_rd_data;

    assign w_wr_en  = i_fWr & ~o_fFull;
    assign w_rd_en  = i_fRd & ~o_fEmpty;

    // Storage array write port
    always_ff @(posedge Clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_WrData;
        end
    end

    // Pointer update and registered head capture on pop
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_buf.sv
// ============================================================================
//  Module      : uart_tx_buf
//  Description : Buffered, parametrised UART transmitter. Words written into
//                an internal FIFO are serialised back-to-back on o_Tx with
//                configurable data width, parity and stop bits.
//                Optional macro UART_TX_BREAK_EN adds i_fBreak, which holds
//                the line low while idle and suspends FIFO draining.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          i_fWr,
    input  logic [DATA_W-1:0]             i_Data,
`ifdef UART_TX_BREAK_EN
    input  logic                          i_fBreak,
`endif
    output logic                          o_fFull,
    output logic                          o_fEmpty,
    output logic [$clog2(FIFO_DEPTH):0]   o_Level,
    output logic                          o_fOvf,
    output logic                          o_fBusy,
    output logic                          o_fDone,
    output logic                          o_Tx
);

    localparam int c_DIV = calc_div(CLK_HZ, BAUD);
    localparam int c_CW  = $clog2(c_DIV);
    localparam int c_BW  = $clog2(DATA_W);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_BW-1:0]   r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              r_tx;
    logic              r_done;
    logic              r_ovf;

    logic              w_pop;
    logic              w_tx;
    logic              w_done;
    logic              w_bit_end;
    logic              w_data_last;
    logic              w_stop_last;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_brk_tx;
    logic              w_drain_ok;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Rst      (Rst),
        .i_fWr    (i_fWr),
        .i_WrData (i_Data),
        .i_fRd    (w_pop),
        .o_RdData (w_fifo_data),
        .o_fFull  (w_fifo_full),
        .o_fEmpty (w_fifo_empty),
        .o_Level  (o_Level)
    );

`ifdef UART_TX_BREAK_EN
    logic r_brk;

    // Delayed break so draining restarts one cycle after the line is released
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_brk <= 1'b0;
        end else begin
            r_brk <= i_fBreak;
        end
    end

    assign w_brk_tx   = i_fBreak;
    assign w_drain_ok = ~i_fBreak & ~r_brk;
`else
    assign w_brk_tx   = 1'b0;
    assign w_drain_ok = 1'b1;
`endif

    assign w_bit_end   = (r_cnt == c_CW'(c_DIV - 1));
    assign w_data_last = (r_bit == c_BW'(DATA_W - 1));
    assign w_stop_last = (r_bit == c_BW'(STOP_BITS - 1));

    assign o_fFull  = w_fifo_full;
    assign o_fEmpty = w_fifo_empty;
    assign o_fOvf   = r_ovf;
    assign o_fBusy  = (r_state != ST_IDLE);
    assign o_fDone  = r_done;
    assign o_Tx     = r_tx;

    // FSM state register
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, pop request and line level for the current state
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx        = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx = ~w_brk_tx;
                if (!w_fifo_empty && w_drain_ok) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_tx = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_tx = r_shift[0];
                if (w_bit_end && w_data_last) begin
                    w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_tx = r_par;
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                w_tx = 1'b1;
                if (w_bit_end && w_stop_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit timer, bit counter, shift register and parity bit
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE || w_bit_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state != w_state_nxt) begin
                r_bit <= '0;
            end else if (w_bit_end && (r_state == ST_DATA || r_state == ST_STOP)) begin
                r_bit <= r_bit + 1'b1;
            end

            // The popped word sits in the FIFO read register through START
            if (r_state == ST_START && w_bit_end) begin
                r_shift <= w_fifo_data;
                r_par   <= (PARITY == PAR_ODD) ? ~(^w_fifo_data) : ^w_fifo_data;
            end else if (r_state == ST_DATA && w_bit_end) begin
                r_shift <= {1'b0, r_shift[DATA_W-1:1]};
            end
        end
    end

    // Registered line, done pulse and overflow pulse
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_tx   <= 1'b1;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_tx   <= w_tx;
            r_done <= w_done;
            r_ovf  <= i_fWr & w_fifo_full;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
// ============================================================================
//  Module      : tb_uart_tx_buf
//  Description : Directed self-checking bench for uart_tx_buf. Three
//                instances at DIV=10: A (8N1, FIFO depth 4), B (odd parity,
//                two stop bits), C (even parity, one stop bit).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_buf;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [2:0] wr;
    logic [2:0] brk;
    logic [7:0] d0, d1, d2;
    logic [2:0] full, empty, ovf, busy, done, tx;
    logic [2:0] lvl0;
    logic [4:0] lvl1, lvl2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n0     = 0;
    int exp_lvl [6] = '{1, 1, 2, 3, 4, 4};

    always #5 Clk = ~Clk;

    uart_tx_buf #(.CLK_HZ(1000000), .BAUD(100000), .DATA_W(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .Clk(Clk), .Rst(Rst), .i_fWr(wr[0]), .i_Data(d0),
`ifdef UART_TX_BREAK_EN
        .i_fBreak(brk[0]),
`endif
        .o_fFull(full[0]), .o_fEmpty(empty[0]), .o_Level(lvl0), .o_fOvf(ovf[0]),
        .o_fBusy(busy[0]), .o_fDone(done[0]), .o_Tx(tx[0]));

    uart_tx_buf #(.CLK_HZ(1000000), .BAUD(100000), .DATA_W(8), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(16)) u_b (
        .Clk(Clk), .Rst(Rst), .i_fWr(wr[1]), .i_Data(d1),
`ifdef UART_TX_BREAK_EN
        .i_fBreak(brk[1]),
`endif
        .o_fFull(full[1]), .o_fEmpty(empty[1]), .o_Level(lvl1), .o_fOvf(ovf[1]),
        .o_fBusy(busy[1]), .o_fDone(done[1]), .o_Tx(tx[1]));

    uart_tx_buf #(.CLK_HZ(1000000), .BAUD(100000), .DATA_W(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) u_c (
        .Clk(Clk), .Rst(Rst), .i_fWr(wr[2]), .i_Data(d2),
`ifdef UART_TX_BREAK_EN
        .i_fBreak(brk[2]),
`endif
        .o_fFull(full[2]), .o_fEmpty(empty[2]), .o_Level(lvl2), .o_fOvf(ovf[2]),
        .o_fBusy(busy[2]), .o_fDone(done[2]), .o_Tx(tx[2]));

    task automatic tick();
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks a whole frame, 10 clocks per bit, starting on its first cycle;
    // bits[0] is the start bit. o_fDone must be high only on the last clock.
    task automatic frame_check(input int sel, input logic [15:0] bits, input int n,
                               input string tag);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < 10; c++) begin
                chk({tag, "_tx"}, 32'(tx[sel]), 32'(bits[b]));
                chk({tag, "_done"}, 32'(done[sel]), 32'((b == n - 1) && (c == 9)));
                tick();
            end
        end
    endtask

    initial begin
        Rst = 1'b0;
        wr  = '0;
        brk = '0;
        d0  = '0;
        d1  = '0;
        d2  = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_tx",    32'(tx[0]),    32'd1);
        chk("rst_full",  32'(full[0]),  32'd0);
        chk("rst_empty", 32'(empty[0]), 32'd1);
        chk("rst_level", 32'(lvl0),     32'd0);
        chk("rst_ovf",   32'(ovf[0]),   32'd0);
        chk("rst_busy",  32'(busy[0]),  32'd0);
        chk("rst_done",  32'(done[0]),  32'd0);
        chk("rst_tx_b",  32'(tx[1]),    32'd1);
        Rst = 1'b1;
        tick();

        // ---------------- single 8N1 frame, 0x3C ----------------
        d0 = 8'h3C;
        wr[0] = 1'b1;
        tick();
        wr[0] = 1'b0;
        chk("w1_level", 32'(lvl0),     32'd1);
        chk("w1_empty", 32'(empty[0]), 32'd0);
        chk("w1_tx",    32'(tx[0]),    32'd1);
        chk("w1_busy",  32'(busy[0]),  32'd0);
        tick();
        chk("pop_busy",  32'(busy[0]), 32'd1);
        chk("pop_level", 32'(lvl0),    32'd0);
        chk("pop_tx",    32'(tx[0]),   32'd1);
        tick();
        frame_check(0, 16'({1'b1, 8'h3C, 1'b0}), 10, "f3c");
        chk("f3c_idle_tx",   32'(tx[0]),   32'd1);
        chk("f3c_idle_busy", 32'(busy[0]), 32'd0);
        chk("f3c_idle_done", 32'(done[0]), 32'd0);

        // ---------------- three back-to-back frames ----------------
        d0 = 8'hE5;
        wr[0] = 1'b1;
        tick();
        chk("b2b_lvl1", 32'(lvl0), 32'd1);
        d0 = 8'h3C;
        tick();
        chk("b2b_lvl2", 32'(lvl0), 32'd1);
        d0 = 8'hA7;
        tick();
        wr[0] = 1'b0;
        chk("b2b_lvl3", 32'(lvl0), 32'd2);
        frame_check(0, 16'({1'b1, 8'hE5, 1'b0}), 10, "fe5");
        chk("gap1_tx",  32'(tx[0]), 32'd1);
        chk("gap1_lvl", 32'(lvl0),  32'd1);
        tick();
        frame_check(0, 16'({1'b1, 8'h3C, 1'b0}), 10, "f3c2");
        chk("gap2_tx",  32'(tx[0]), 32'd1);
        chk("gap2_lvl", 32'(lvl0),  32'd0);
        tick();
        frame_check(0, 16'({1'b1, 8'hA7, 1'b0}), 10, "fa7");
        chk("b2b_end_busy",  32'(busy[0]),  32'd0);
        chk("b2b_end_empty", 32'(empty[0]), 32'd1);
        chk("b2b_end_tx",    32'(tx[0]),    32'd1);

        // ---------------- fill to full, overflow ----------------
        for (int k = 0; k < 6; k++) begin
            d0 = 8'h50 + 8'(k);
            wr[0] = 1'b1;
            tick();
            if (k == 0) n0 = cyc;
            chk("ovf_level", 32'(lvl0), 32'(exp_lvl[k]));
            chk("ovf_full",  32'(full[0]), 32'(k >= 4));
            chk("ovf_pulse", 32'(ovf[0]),  32'(k == 5));
        end
        wr[0] = 1'b0;
        tick();
        chk("ovf_clear", 32'(ovf[0]), 32'd0);
        chk("ovf_hold",  32'(lvl0),   32'd4);

        // write on the same edge as the pop from a full FIFO is dropped
        while (cyc < n0 + 101) tick();
        chk("coin_full", 32'(full[0]), 32'd1);
        chk("coin_busy", 32'(busy[0]), 32'd0);
        d0 = 8'hFF;
        wr[0] = 1'b1;
        tick();
        wr[0] = 1'b0;
        chk("coin_level", 32'(lvl0),    32'd3);
        chk("coin_ovf",   32'(ovf[0]),  32'd1);
        chk("coin_full2", 32'(full[0]), 32'd0);
        tick();
        chk("coin_ovf2", 32'(ovf[0]), 32'd0);

        // ---------------- reset during DATA bit 3 (word 0x51) ----------------
        while (cyc < n0 + 146) tick();
        chk("mid_busy", 32'(busy[0]), 32'd1);
        chk("mid_tx",   32'(tx[0]),   32'd0);
        Rst = 1'b0;
        tick();
        chk("mrst_tx",    32'(tx[0]),    32'd1);
        chk("mrst_busy",  32'(busy[0]),  32'd0);
        chk("mrst_level", 32'(lvl0),     32'd0);
        chk("mrst_empty", 32'(empty[0]), 32'd1);
        chk("mrst_done",  32'(done[0]),  32'd0);
        Rst = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick();
            chk("post_rst_done", 32'(done[0]), 32'd0);
            chk("post_rst_tx",   32'(tx[0]),   32'd1);
        end

        // ---------------- odd parity, two stop bits: 0xE5 -> parity 0 ----------------
        d1 = 8'hE5;
        wr[1] = 1'b1;
        tick();
        wr[1] = 1'b0;
        tick();
        tick();
        frame_check(1, 16'({2'b11, 1'b0, 8'hE5, 1'b0}), 12, "odd");
        chk("odd_busy", 32'(busy[1]), 32'd0);
        chk("odd_tx",   32'(tx[1]),   32'd1);

        // ---------------- even parity: 0xE5 -> parity 1 ----------------
        d2 = 8'hE5;
        wr[2] = 1'b1;
        tick();
        wr[2] = 1'b0;
        tick();
        tick();
        frame_check(2, 16'({1'b1, 1'b1, 8'hE5, 1'b0}), 11, "even");
        chk("even_busy", 32'(busy[2]), 32'd0);
        chk("even_tx",   32'(tx[2]),   32'd1);

`ifdef UART_TX_BREAK_EN
        // ---------------- break held 50 clocks with 0x55 queued ----------------
        brk[0] = 1'b1;
        d0 = 8'h55;
        wr[0] = 1'b1;
        tick();
        wr[0] = 1'b0;
        chk("brk_tx0", 32'(tx[0]), 32'd0);
        chk("brk_lvl", 32'(lvl0),  32'd1);
        for (int i = 1; i < 50; i++) begin
            tick();
            chk("brk_tx",   32'(tx[0]),   32'd0);
            chk("brk_busy", 32'(busy[0]), 32'd0);
        end
        brk[0] = 1'b0;
        tick();
        chk("rel_tx",   32'(tx[0]),   32'd1);
        chk("rel_busy", 32'(busy[0]), 32'd0);
        chk("rel_lvl",  32'(lvl0),    32'd1);
        tick();
        chk("rel_pop_busy", 32'(busy[0]), 32'd1);
        chk("rel_pop_tx",   32'(tx[0]),   32'd1);
        tick();
        frame_check(0, 16'({1'b1, 8'h55, 1'b0}), 10, "f55");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
